// File: rtl/bsg_dram_channel_arbiter_pkg.sv
// Shared types for the DRAM channel arbiter: output-register FSM states and the held request.
// The request struct's address field sets the widest channel address the arbiter can carry.
package bsg_dram_channel_arbiter_pkg;

    localparam int ch_addr_width_gp = 29;

    typedef enum logic {
        e_empty,
        e_hold
    } arb_state_e;

    typedef struct packed {
        logic                        write_not_read;
        logic [ch_addr_width_gp-1:0] ch_addr;
    } dram_req_s;

    // Index width that stays legal for a single-entry range.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with one write and one read port; a full FIFO still accepts
// an enqueue in a cycle where the head is dequeued.
module bsg_fifo_1r1w_small
    import bsg_dram_channel_arbiter_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                enq, deq;

    assign v_o     = (count_r != '0);
    assign ready_o = (count_r != cnt_w_lp'(els_p)) || yumi_i;
    assign data_o  = mem_r[rd_ptr_r];
    assign enq     = v_i && ready_o;
    assign deq     = yumi_i && v_o;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
            if (enq && !deq)      count_r <= count_r + cnt_w_lp'(1);
            else if (!enq && deq) count_r <= count_r - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_dram_channel_arbiter.sv
// Round-robin arbiter sharing one DRAM channel; read credits bound outstanding reads and a
// tag FIFO routes in-order read responses back. BSG_DRAM_CHANNEL_ARBITER_ASSERT_EN adds sim checks.
module bsg_dram_channel_arbiter
    import bsg_dram_channel_arbiter_pkg::*;
#(
    parameter int num_requesters_p     = 2,
    parameter int channel_addr_width_p = ch_addr_width_gp,
    parameter int max_outstanding_p    = 16
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset_i,
    input  logic [num_requesters_p-1:0]                          v_i,
    input  logic [num_requesters_p-1:0]                          write_not_read_i,
    input  logic [num_requesters_p-1:0][channel_addr_width_p-1:0] ch_addr_i,
    output logic [num_requesters_p-1:0]                          yumi_o,
    output logic                                                 dram_v_o,
    output logic                                                 dram_write_not_read_o,
    output logic [channel_addr_width_p-1:0]                      dram_ch_addr_o,
    input  logic                                                 dram_yumi_i,
    input  logic                                                 dram_data_v_i,
    output logic [num_requesters_p-1:0]                          data_v_o
);
    localparam int id_w_lp   = safe_clog2(num_requesters_p);
    localparam int cred_w_lp = $clog2(max_outstanding_p + 1);

    arb_state_e           state_r, state_n;
    dram_req_s            req_r, req_n;
    logic [id_w_lp-1:0]   id_r, rr_ptr_r, winner, tag_head;
    logic [id_w_lp:0]     winner_inc;
    logic [cred_w_lp-1:0] credits_r;
    logic [num_requesters_p-1:0] eligible;
    logic found, capture_en, grant, read_grant, credit_ret;
    logic tag_enq, tag_ready, tag_v, tag_deq;

    // Reads drop out of the race while credits are exhausted; writes never do.
    assign eligible = v_i & (write_not_read_i | {num_requesters_p{credits_r != cred_w_lp'(max_outstanding_p)}});

    always_comb begin
        logic [id_w_lp:0] idx;
        idx    = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < num_requesters_p; k++) begin
            idx = {1'b0, rr_ptr_r} + (id_w_lp+1)'(k);
            if (idx >= (id_w_lp+1)'(num_requesters_p)) idx = idx - (id_w_lp+1)'(num_requesters_p);
            if (!found && eligible[idx[id_w_lp-1:0]]) begin
                found  = 1'b1;
                winner = idx[id_w_lp-1:0];
            end
        end
    end

    assign winner_inc = {1'b0, winner} + (id_w_lp+1)'(1);
    assign capture_en = (state_r == e_empty) || dram_yumi_i;
    assign grant      = capture_en && found && !reset_i;
    assign read_grant = grant && !write_not_read_i[winner];
    assign yumi_o     = grant ? (num_requesters_p'(1) << winner) : '0;
    assign credit_ret = dram_data_v_i && (credits_r != '0);

    always_comb begin
        req_n.write_not_read = write_not_read_i[winner];
        req_n.ch_addr        = ch_addr_width_gp'(ch_addr_i[winner]);
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_empty: if (grant) state_n = e_hold;
            e_hold:  if (dram_yumi_i) state_n = grant ? e_hold : e_empty;
            default: state_n = e_empty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_empty;
            credits_r <= '0;
            rr_ptr_r  <= '0;
            req_r     <= '0;
            id_r      <= '0;
        end else begin
            state_r <= state_n;
            if (grant) begin
                req_r    <= req_n;
                id_r     <= winner;
                rr_ptr_r <= (winner_inc == (id_w_lp+1)'(num_requesters_p)) ? '0 : winner_inc[id_w_lp-1:0];
            end
            if (read_grant && !credit_ret)      credits_r <= credits_r + cred_w_lp'(1);
            else if (!read_grant && credit_ret) credits_r <= credits_r - cred_w_lp'(1);
        end
    end

    assign dram_v_o              = (state_r == e_hold);
    assign dram_write_not_read_o = req_r.write_not_read;
    assign dram_ch_addr_o        = channel_addr_width_p'(req_r.ch_addr);

    // Tags are taken at channel acceptance, so response order matches issue order.
    assign tag_enq = dram_v_o && dram_yumi_i && !req_r.write_not_read && tag_ready;
    assign tag_deq = dram_data_v_i && tag_v;

    bsg_fifo_1r1w_small #(
        .width_p(id_w_lp),
        .els_p  (max_outstanding_p)
    ) tag_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (tag_enq),
        .ready_o(tag_ready),
        .data_i (id_r),
        .v_o    (tag_v),
        .data_o (tag_head),
        .yumi_i (tag_deq)
    );

    assign data_v_o = (tag_deq && !reset_i) ? (num_requesters_p'(1) << tag_head) : '0;

`ifdef BSG_DRAM_CHANNEL_ARBITER_ASSERT_EN
    logic      stall_r;
    dram_req_s req_prev_r;

    always_ff @(posedge clk_i) begin
        stall_r    <= !reset_i && dram_v_o && !dram_yumi_i;
        req_prev_r <= req_r;
        if (!reset_i) begin
            if (dram_data_v_i && credits_r == '0)
                $error("dram_data_v_i with no reads outstanding");
            if (stall_r && (!dram_v_o || req_r != req_prev_r))
                $error("DRAM request changed while held without dram_yumi_i");
            if (!$onehot0(yumi_o))
                $error("yumi_o not one-hot: %b", yumi_o);
        end
    end
`endif

endmodule
